logic_op_sweeper: RTL

Sequential stimulus/capture stage in front of the selectable logic unit `Guia_0703` (inputs `a`, `b`, `chave1`, `chave2`; output `y`; select 00 AND, 01 NAND, 10 OR, 11 NOR).
- On `start`, it steps through all 16 input/select combinations and holds each for a programmable settle time.
- It samples the unit's `y` for each combination into a 16-bit truth table.
- On completion it flags any mismatch against the golden table.

---
 rtl/logic_op_sweeper_pkg.sv | 21 ++
 rtl/logic_op_sweeper_hold_timer.sv | 24 ++
 rtl/logic_op_sweeper.sv | 99 +++++++++
 3 files changed

// File: rtl/logic_op_sweeper_pkg.sv
// Shared constants for the logic-unit sweeper: FSM encodings, op selects
// and the truth table a correct logic unit must produce.
package logic_op_sweeper_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Select encoding {chave1, chave2} understood by the logic unit.
  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_NAND = 2'b01,
    OP_OR   = 2'b10,
    OP_NOR  = 2'b11
  } op_e;

  localparam logic [15:0] GOLDEN_TABLE = 16'h1E78;
  localparam logic [3:0]  IDX_LAST     = 4'd15;

endpackage

// File: rtl/logic_op_sweeper_hold_timer.sv
// Loadable 4-bit down-counter setting how long each combination is driven.
module hold_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] value,
  output logic       expired
);

  logic [3:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)                    count <= 4'd0;
    else if (load)                count <= value;
    else if (en && count != 4'd0) count <= count - 4'd1;
  end

  // The last DRIVE cycle is the one that sees a count of 1.
  assign expired = (count == 4'd1);

endmodule

// File: rtl/logic_op_sweeper.sv
// Walks all 16 select/operand combinations through an external logic unit,
// captures its output into a truth table and flags any golden mismatch.
module logic_op_sweeper
  import logic_op_sweeper_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        y,
  output logic        a,
  output logic        b,
  output logic        chave1,
  output logic        chave2,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic        err
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("HOLD_CYCLES must be in 1..15");
  end

  logic [1:0] state;
  logic [3:0] idx;
  logic [3:0] sel;
  logic       timer_load;
  logic       timer_expired;

  // Reload on sweep start and on every SAMPLE that moves on to a new index.
  assign timer_load = (state == S_IDLE && start) ||
                      (state == S_SAMPLE && idx != IDX_LAST);

  hold_timer u_hold_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .en      (state == S_DRIVE),
    .value   (4'(HOLD_CYCLES)),
    .expired (timer_expired)
  );

  // NOTE: table_out is a plain 16-bit register, not a memory, so it is reset
  // along with the rest of the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= 4'd0;
      sel       <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= 16'd0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            table_out <= 16'd0;
            err       <= 1'b0;
            idx       <= 4'd0;
            sel       <= 4'd0;
            busy      <= 1'b1;
            state     <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (timer_expired) state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          // y reflects sel == idx here; the write uses the pre-increment index.
          table_out[idx] <= y;
          if (idx == IDX_LAST) begin
            sel   <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx   <= idx + 4'd1;
            sel   <= idx + 4'd1;
            state <= S_DRIVE;
          end
        end
        default: begin
          err   <= (table_out != GOLDEN_TABLE);
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign chave1 = sel[3];
  assign chave2 = sel[2];
  assign a      = sel[1];
  assign b      = sel[0];

endmodule
